// File: rtl/incubator_actuator_driver_pkg.sv
// Shared definitions for the incubator actuator driver: heater FSM encoding,
// default timing parameters and the controller's CRS speed levels.
package incubator_actuator_driver_pkg;

  typedef enum logic {
    H_OFF = 1'b0,
    H_ON  = 1'b1
  } heater_state_t;

  localparam int DEF_MAX_CRS      = 8;
  localparam int DEF_RAMP_PERIODS = 2;
  localparam int DEF_MIN_DWELL    = 16;

  localparam logic [7:0] CRS_OFF  = 8'd0;
  localparam logic [7:0] CRS_LOW  = 8'd4;
  localparam logic [7:0] CRS_MID  = 8'd6;
  localparam logic [7:0] CRS_HIGH = 8'd8;

endpackage

// File: rtl/incubator_actuator_driver_fan_pwm_ramp.sv
// Fan PWM generator with a slew-limited speed level that steps one unit toward
// the target every RAMP_PERIODS PWM periods, only at period boundaries.
module fan_pwm_ramp #(
  parameter int MAX_CRS      = 8,
  parameter int RAMP_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target,
  output logic       fan_pwm,
  output logic [7:0] fan_speed,
  output logic       ramping
);

  localparam logic [7:0] PWM_LAST  = 8'(MAX_CRS - 1);
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_PERIODS - 1);

  logic [7:0] pwm_cnt;
  logic [7:0] ramp_cnt;
  logic [7:0] ramp_cnt_next;
  logic [7:0] speed_next;
  logic       boundary;

  assign boundary = (pwm_cnt == PWM_LAST);

  // ramp_cnt survives target changes, so a redirected ramp keeps its phase
  always_comb begin
    speed_next    = fan_speed;
    ramp_cnt_next = ramp_cnt;
    if (fan_speed == target) begin
      ramp_cnt_next = '0;
    end else if (boundary) begin
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt_next = '0;
        speed_next    = (target > fan_speed) ? fan_speed + 8'd1 : fan_speed - 8'd1;
      end else begin
        ramp_cnt_next = ramp_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      ramp_cnt  <= '0;
      fan_speed <= '0;
      fan_pwm   <= 1'b0;
      ramping   <= 1'b0;
    end else begin
      pwm_cnt   <= boundary ? 8'd0 : pwm_cnt + 8'd1;
      ramp_cnt  <= ramp_cnt_next;
      fan_speed <= speed_next;
      fan_pwm   <= (pwm_cnt < fan_speed);
      ramping   <= (speed_next != target);
    end
  end

endmodule

// File: rtl/incubator_actuator_driver.sv
// Drives the fan (ramped PWM) and heater (dwell-limited, interlocked against
// the cooler) from the incubator controller's registered commands.
module incubator_actuator_driver
  import incubator_actuator_driver_pkg::*;
#(
  parameter int MAX_CRS      = DEF_MAX_CRS,
  parameter int RAMP_PERIODS = DEF_RAMP_PERIODS,
  parameter int MIN_DWELL    = DEF_MIN_DWELL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Cooler,
  input  logic       Heater,
  input  logic [7:0] CRS,
  output logic       fan_pwm,
  output logic [7:0] fan_speed,
  output logic       ramping,
  output logic       heater_on,
  output logic       fault
);

  localparam logic [7:0] CRS_CLAMP = 8'(MAX_CRS);
  localparam int         DW        = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0] DWELL_SAT = DW'(MIN_DWELL);

  logic [7:0]    target;
  logic          conflict;
  logic          heat_req;
  logic          dwell_done;
  logic [DW-1:0] dwell_cnt;
  heater_state_t state;
  heater_state_t state_next;

  // Out-of-range speed commands clamp to full scale rather than wrapping
  assign target     = Cooler ? ((CRS > CRS_CLAMP) ? CRS_CLAMP : CRS) : 8'd0;
  assign conflict   = Cooler & Heater;
  assign heat_req   = Heater & ~Cooler;
  assign dwell_done = (dwell_cnt == DWELL_SAT);
  assign heater_on  = (state == H_ON);

  fan_pwm_ramp #(
    .MAX_CRS      (MAX_CRS),
    .RAMP_PERIODS (RAMP_PERIODS)
  ) u_fan (
    .clk       (clk),
    .reset     (reset),
    .target    (target),
    .fan_pwm   (fan_pwm),
    .fan_speed (fan_speed),
    .ramping   (ramping)
  );

  // A cooler/heater conflict drops the heater at once, bypassing the dwell
  always_comb begin
    state_next = state;
    case (state)
      H_OFF: if (heat_req && dwell_done) state_next = H_ON;
      H_ON: begin
        if (conflict)                    state_next = H_OFF;
        else if (!heat_req && dwell_done) state_next = H_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= H_OFF;
      dwell_cnt <= DWELL_SAT;
      fault     <= 1'b0;
    end else begin
      state <= state_next;
      fault <= conflict;
      if (state_next != state)
        dwell_cnt <= '0;
      else if (!dwell_done)
        dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_incubator_actuator_driver.sv
// Directed self-checking bench for incubator_actuator_driver: fan ramp/PWM,
// heater dwell, conflict interlock and asynchronous reset.
module tb_incubator_actuator_driver;
  import incubator_actuator_driver_pkg::*;

  logic       clk;
  logic       reset;
  logic       Cooler;
  logic       Heater;
  logic [7:0] CRS;
  logic       fan_pwm;
  logic [7:0] fan_speed;
  logic       ramping;
  logic       heater_on;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ones   = 0;

  incubator_actuator_driver dut (
    .clk       (clk),
    .reset     (reset),
    .Cooler    (Cooler),
    .Heater    (Heater),
    .CRS       (CRS),
    .fan_pwm   (fan_pwm),
    .fan_speed (fan_speed),
    .ramping   (ramping),
    .heater_on (heater_on),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic applyStimulus(input logic c, input logic h, input logic [7:0] crs);
    Cooler = c;
    Heater = h;
    CRS    = crs;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic waitSpeed(input string tag, input logic [7:0] want, input int limit);
    int n = 0;
    while (fan_speed !== want && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, fan_speed, want);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_fan_pwm"},   {7'd0, fan_pwm},   8'd0);
    checkOutput({tag, "_fan_speed"}, fan_speed,         8'd0);
    checkOutput({tag, "_ramping"},   {7'd0, ramping},   8'd0);
    checkOutput({tag, "_heater_on"}, {7'd0, heater_on}, 8'd0);
    checkOutput({tag, "_fault"},     {7'd0, fault},     8'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, CRS_OFF);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    // Ramp 0 -> 4, one step every 16 cycles
    applyStimulus(1'b1, 1'b0, CRS_LOW);
    releaseReset();
    tick(15);
    checkOutput("ramp4_c15", fan_speed, 8'd0);
    tick(1);
    checkOutput("ramp4_c16", fan_speed, 8'd1);
    checkOutput("ramp4_ramping_c16", {7'd0, ramping}, 8'd1);
    tick(16);
    checkOutput("ramp4_c32", fan_speed, 8'd2);
    tick(16);
    checkOutput("ramp4_c48", fan_speed, 8'd3);
    tick(15);
    checkOutput("ramp4_c63", fan_speed, 8'd3);
    checkOutput("ramp4_ramping_c63", {7'd0, ramping}, 8'd1);
    tick(1);
    checkOutput("ramp4_c64", fan_speed, 8'd4);
    checkOutput("ramp4_ramping_c64", {7'd0, ramping}, 8'd0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      ones += int'(fan_pwm);
    end
    checkOutput("duty4_of_8", 8'(ones), 8'd4);

    // Over-range CRS clamps to 8, PWM then holds high
    applyStimulus(1'b1, 1'b0, 8'd200);
    waitSpeed("clamp_reach8", 8'd8, 100);
    tick(1);
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      ones += int'(fan_pwm);
    end
    checkOutput("duty8_of_16", 8'(ones), 8'd16);
    checkOutput("clamp_hold8", fan_speed, 8'd8);
    checkOutput("clamp_ramping", {7'd0, ramping}, 8'd0);

    // Ramp down 8 -> 0 from a period start: last step lands at +128
    while (cyc % 8 != 0) tick(1);
    applyStimulus(1'b0, 1'b0, 8'd200);
    tick(16);
    checkOutput("down_c16", fan_speed, 8'd7);
    tick(48);
    checkOutput("down_c64", fan_speed, 8'd4);
    tick(63);
    checkOutput("down_c127", fan_speed, 8'd1);
    checkOutput("down_ramping_c127", {7'd0, ramping}, 8'd1);
    tick(1);
    checkOutput("down_c128", fan_speed, 8'd0);
    checkOutput("down_ramping_c128", {7'd0, ramping}, 8'd0);

    // Heater dwell after a fresh reset
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, CRS_OFF);
    releaseReset();
    tick(1);
    checkOutput("heat_on_c1", {7'd0, heater_on}, 8'd1);
    tick(2);
    applyStimulus(1'b0, 1'b0, CRS_OFF);
    tick(14);
    checkOutput("heat_hold_c17", {7'd0, heater_on}, 8'd1);
    tick(1);
    checkOutput("heat_off_c18", {7'd0, heater_on}, 8'd0);

    // Short request inside the off-dwell is ignored
    tick(10);
    applyStimulus(1'b0, 1'b1, CRS_OFF);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("pulse_ignored", {7'd0, heater_on}, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, CRS_OFF);
    tick(5);
    checkOutput("pulse_after", {7'd0, heater_on}, 8'd0);
    applyStimulus(1'b0, 1'b1, CRS_OFF);
    tick(1);
    checkOutput("heat_on_dwell_met", {7'd0, heater_on}, 8'd1);

    // Conflict forces heater off despite dwell
    applyStimulus(1'b1, 1'b1, CRS_OFF);
    tick(1);
    checkOutput("conflict_fault", {7'd0, fault}, 8'd1);
    checkOutput("conflict_heat_off", {7'd0, heater_on}, 8'd0);
    applyStimulus(1'b0, 1'b0, CRS_OFF);
    tick(1);
    checkOutput("fault_clears", {7'd0, fault}, 8'd0);
    applyStimulus(1'b1, 1'b1, CRS_OFF);
    tick(1);
    checkOutput("both_rise_fault", {7'd0, fault}, 8'd1);
    checkOutput("both_rise_heat", {7'd0, heater_on}, 8'd0);
    applyStimulus(1'b0, 1'b0, CRS_OFF);
    tick(1);

    // Reset mid-ramp with heater on
    applyStimulus(1'b1, 1'b0, CRS_HIGH);
    waitSpeed("pre_reset_up8", 8'd8, 200);
    applyStimulus(1'b0, 1'b1, CRS_HIGH);
    waitSpeed("pre_reset_down5", 8'd5, 100);
    checkOutput("pre_reset_heat", {7'd0, heater_on}, 8'd1);
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    applyStimulus(1'b1, 1'b0, CRS_MID);
    releaseReset();
    tick(15);
    checkOutput("restart_c15", fan_speed, 8'd0);
    tick(1);
    checkOutput("restart_c16", fan_speed, 8'd1);
    checkOutput("restart_heat", {7'd0, heater_on}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/incubator_actuator_driver.md
# incubator_actuator_driver

Converts the incubator controller's registered actuator commands (Cooler, Heater, CRS) into physical drive signals. Sits directly downstream of the incubator state machine. Produces a PWM fan drive whose speed slews gradually toward the commanded cooler rotation speed, and a heater drive with enforced minimum on/off dwell. A cooler/heater conflict interlock forces the heater off.

## Interface
- MAX_CRS, 8: full-scale speed; PWM period in cycles; clamp for CRS.
- RAMP_PERIODS, 2: PWM periods per ±1 speed step.
- MIN_DWELL, 16: minimum cycles heater_on holds a level before it may toggle.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- Cooler  in  1  cooler request from controller.
- Heater  in  1  heater request from controller.
- CRS  in  8  commanded cooler rotation speed, unsigned.
- fan_pwm  out  1  fan PWM drive, registered.
- fan_speed  out  8  current (ramped) speed level, registered.
- ramping  out  1  high while fan_speed != target, registered.
- heater_on  out  1  heater drive, registered.
- fault  out  1  Cooler and Heater both requested last cycle, registered.

## Operation
- Reset values: fan_pwm=0, fan_speed=0, ramping=0, heater_on=0, fault=0, pwm_cnt=0, ramp_cnt=0, heater FSM=H_OFF, dwell_cnt=MIN_DWELL (saturated).
- target = Cooler ? min(CRS, MAX_CRS) : 0. CRS > MAX_CRS is clamped, never wrapped.
- pwm_cnt counts 0..MAX_CRS-1 and wraps. A boundary is a cycle with pwm_cnt==MAX_CRS-1.
- fan_pwm <= (pwm_cnt < fan_speed).
  - fan_speed=0 gives constant low.
  - fan_speed=MAX_CRS gives constant high.
- Ramp:
  - If fan_speed==target, ramp_cnt is held at 0.
  - Otherwise, at each boundary ramp_cnt increments. At a boundary with ramp_cnt==RAMP_PERIODS-1, fan_speed moves one step toward target and ramp_cnt is cleared.
  - fan_speed changes only at boundaries, so no PWM glitches occur.
  - If target changes mid-ramp, direction follows the new target; ramp_cnt is not cleared.
- ramping <= (fan_speed_next != target).
- Interlock: heat_req = Heater & ~Cooler. fault <= Cooler & Heater. fault is non-sticky and has no effect on the fan path.
- Heater FSM, states H_OFF and H_ON:
  - dwell_cnt saturates at MIN_DWELL and is cleared to 0 on every state change.
  - H_OFF -> H_ON when heat_req=1 and dwell_cnt==MIN_DWELL.
  - H_ON -> H_OFF when heat_req=0 and dwell_cnt==MIN_DWELL.
  - Exception: a fault cycle forces H_ON -> H_OFF immediately, ignoring dwell.
  - heater_on = (state==H_ON).
- Reset mid-operation: all outputs drop asynchronously. fan_speed returns to 0 instantly, with no ramp-down.

## Timing
- heater_on rises or falls 1 cycle after the qualifying input edge, provided dwell is satisfied. Otherwise it changes on the first cycle dwell is satisfied and the request still holds.
- Request pulses shorter than the remaining dwell are ignored.
- fault: 1-cycle latency. Forced heater-off also takes 1 cycle.
- Speed step spacing: MAX_CRS*RAMP_PERIODS cycles (16 with defaults). A 0→8 ramp takes 128 cycles.
- fan_pwm lags pwm_cnt/fan_speed by 1 cycle. Duty = fan_speed/MAX_CRS per period.
- Simultaneous events:
  - A target change on a boundary cycle uses the new target for that cycle's step decision.
  - Cooler and Heater both rising in the same cycle gives fault=1, heater stays off, and the fan ramps normally.

## Structure
- Shared package:
  - heater state encoding H_OFF=1'b0, H_ON=1'b1;
  - MAX_CRS, RAMP_PERIODS, MIN_DWELL defaults;
  - the controller's CRS level constants 0/4/6/8.
- One natural sub-module: fan_pwm_ramp, containing pwm_cnt, ramp_cnt, fan_speed, fan_pwm and ramping.
- The heater FSM, interlock and fault logic stay in the top.

## Test plan
- Reset release, then Cooler=1, CRS=4:
  - fan_speed steps 1,2,3,4 at cycles 16,32,48,64 after release;
  - ramping then drops to 0;
  - fan_pwm is high 4 of every 8 cycles.
- CRS=200, Cooler=1: fan_speed ramps to 8 and stops; fan_pwm holds constant 1. Then Cooler=0: fan_speed ramps down 8→0 over 128 cycles.
- Heater=1 at cycle 0 after reset: heater_on=1 at cycle 1. Heater=0 at cycle 3: heater_on stays 1 until cycle 17, then 0.
- Heater=1 with Cooler=1 for one cycle while heater_on=1: fault=1 the next cycle and heater_on=0 the same cycle, regardless of dwell.
- Heater pulses of 5 cycles, issued 10 cycles after heater_on falls: no heater_on response.
- Assert reset for 1 cycle mid-ramp at fan_speed=5 with heater_on=1: all outputs are 0 immediately. After release, ramp restarts from 0.
